// File: rtl/vending_pkg.sv
// Shared definitions for the parametrised vending controller.
// Holds default parameter values, coin code constants with a value lookup,
// the controller state type and the per-item price table.
package vending_pkg;

   localparam int unsigned DEF_NUM_ITEMS  = 6;
   localparam int unsigned DEF_CREDIT_W   = 8;
   localparam int unsigned DEF_STOCK_W    = 4;
   localparam int unsigned DEF_INIT_STOCK = 5;
   localparam int unsigned DEF_MAX_CREDIT = 200;

   localparam logic [1:0] COIN_5  = 2'b00;
   localparam logic [1:0] COIN_10 = 2'b01;
   localparam logic [1:0] COIN_20 = 2'b10;
   localparam logic [1:0] COIN_50 = 2'b11;

   localparam int unsigned NUM_PRICES = 6;
   localparam int unsigned PRICE_TABLE [NUM_PRICES] = '{15, 25, 35, 45, 55, 65};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      CHANGE  = 2'd3
   } state_e;

   // Face value of a coin code.
   function automatic int unsigned coin_value(input logic [1:0] code);
      int unsigned v;
      v = 5;
      case (code)
         COIN_5:  v = 5;
         COIN_10: v = 10;
         COIN_20: v = 20;
         COIN_50: v = 50;
         default: v = 5;
      endcase
      return v;
   endfunction

   // Price of an item; indices past the table reuse the last entry.
   function automatic int unsigned item_price(input int unsigned idx);
      int unsigned p;
      p = PRICE_TABLE[NUM_PRICES-1];
      case (idx)
         0:       p = PRICE_TABLE[0];
         1:       p = PRICE_TABLE[1];
         2:       p = PRICE_TABLE[2];
         3:       p = PRICE_TABLE[3];
         4:       p = PRICE_TABLE[4];
         5:       p = PRICE_TABLE[5];
         default: p = PRICE_TABLE[NUM_PRICES-1];
      endcase
      return p;
   endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters for the vending controller.
// Ports: clock, reset (sync, active-low), dec_en/dec_idx (take one unit of an
// item), reload (refill every item to INIT_STOCK), empty (per-item zero flags,
// registered alongside the counters).
module vm_stock_bank
   import vending_pkg::*;
#(
   parameter int unsigned NUM_ITEMS  = DEF_NUM_ITEMS,
   parameter int unsigned STOCK_W    = DEF_STOCK_W,
   parameter int unsigned INIT_STOCK = DEF_INIT_STOCK,
   parameter int unsigned IDX_W      = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 dec_en,
   input  logic [IDX_W-1:0]     dec_idx,
   input  logic                 reload,
   output logic [NUM_ITEMS-1:0] empty
);

   logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
   logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
   logic [NUM_ITEMS-1:0] empty_q;
   logic [NUM_ITEMS-1:0] empty_d;

   // Next counts; the zero guard keeps a counter from wrapping.
   always_comb begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
         stock_d[i] = stock_q[i];
         if (reload) begin
            stock_d[i] = STOCK_W'(INIT_STOCK);
         end else if (dec_en && (dec_idx == IDX_W'(i)) && (stock_q[i] != '0)) begin
            stock_d[i] = stock_q[i] - STOCK_W'(1);
         end
         empty_d[i] = (stock_d[i] == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_q[i] <= STOCK_W'(INIT_STOCK);
         end
         empty_q <= (INIT_STOCK == 0) ? '1 : '0;
      end else begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_q[i] <= stock_d[i];
         end
         empty_q <= empty_d;
      end
   end

   assign empty = empty_q;

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised multi-item vending controller: accumulates coins, checks stock
// and price, dispenses, then returns change in a following cycle.
// Inputs : clock, reset (sync, active-low), coin_valid/coin_code, sel_valid/sel,
//          cancel, restock.
// Outputs: out/out_item (dispense pulse), change/change_valid (change pulse),
//          credit, busy, coin_reject, sold_out, err -- all registered.
// Build option VM_SALES_AUDIT_EN adds saturating revenue and vend_count ports.
module vending_machine_param
   import vending_pkg::*;
#(
   parameter int unsigned NUM_ITEMS  = DEF_NUM_ITEMS,
   parameter int unsigned CREDIT_W   = DEF_CREDIT_W,
   parameter int unsigned STOCK_W    = DEF_STOCK_W,
   parameter int unsigned INIT_STOCK = DEF_INIT_STOCK,
   parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT,
   parameter int unsigned SEL_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                coin_valid,
   input  logic [1:0]          coin_code,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel,
   input  logic                cancel,
   input  logic                restock,
   output logic                out,
   output logic [SEL_W-1:0]    out_item,
   output logic [CREDIT_W-1:0] change,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic                coin_reject,
   output logic                sold_out,
   output logic                err
`ifdef VM_SALES_AUDIT_EN
   ,
   output logic [15:0]         revenue,
   output logic [15:0]         vend_count
`endif
);

   localparam int unsigned SUM_W    = CREDIT_W + 1;
   localparam int unsigned SEL_SPAN = 1 << SEL_W;

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [SEL_W-1:0]    vend_item_q, vend_item_d;
   logic                out_q, out_d;
   logic [SEL_W-1:0]    out_item_q, out_item_d;
   logic [CREDIT_W-1:0] change_q, change_d;
   logic                change_valid_q, change_valid_d;
   logic                busy_q, busy_d;
   logic                coin_reject_q, coin_reject_d;
   logic                sold_out_q, sold_out_d;
   logic                err_q, err_d;

   logic                dec_en_c;
   logic                reload_c;
   logic [NUM_ITEMS-1:0] stock_empty;
   logic [SEL_SPAN-1:0] empty_pad_c;
   logic [SUM_W-1:0]    coin_sum_c;
   logic [CREDIT_W-1:0] sel_price_c;

   vm_stock_bank #(
      .NUM_ITEMS  (NUM_ITEMS),
      .STOCK_W    (STOCK_W),
      .INIT_STOCK (INIT_STOCK),
      .IDX_W      (SEL_W)
   ) u_stock (
      .clock   (clock),
      .reset   (reset),
      .dec_en  (dec_en_c),
      .dec_idx (sel),
      .reload  (reload_c),
      .empty   (stock_empty)
   );

   // Out-of-range indices read as empty; the range check catches them first.
   always_comb begin
      empty_pad_c                = '1;
      empty_pad_c[NUM_ITEMS-1:0] = stock_empty;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      vend_item_d    = vend_item_q;
      out_d          = 1'b0;
      out_item_d     = out_item_q;
      change_d       = change_q;
      change_valid_d = 1'b0;
      coin_reject_d  = 1'b0;
      sold_out_d     = 1'b0;
      err_d          = 1'b0;
      dec_en_c       = 1'b0;
      reload_c       = 1'b0;
      coin_sum_c     = {1'b0, credit_q} + SUM_W'(coin_value(coin_code));
      sel_price_c    = CREDIT_W'(item_price(32'(sel)));

      case (state_q)
         IDLE, COLLECT: begin
            // One action per cycle: cancel > sel_valid > coin_valid > restock.
            if (cancel) begin
               coin_reject_d = coin_valid;
               if (state_q == COLLECT) begin
                  state_d = CHANGE;
               end
            end else if (sel_valid) begin
               coin_reject_d = coin_valid;
               if (32'(sel) >= NUM_ITEMS) begin
                  err_d = 1'b1;
               end else if (empty_pad_c[sel]) begin
                  sold_out_d = 1'b1;
               end else if (credit_q < sel_price_c) begin
                  err_d = 1'b1;
               end else begin
                  state_d     = VEND;
                  credit_d    = credit_q - sel_price_c;
                  vend_item_d = sel;
                  dec_en_c    = 1'b1;
               end
            end else if (coin_valid) begin
               if (coin_sum_c > SUM_W'(MAX_CREDIT)) begin
                  coin_reject_d = 1'b1;
               end else begin
                  credit_d = coin_sum_c[CREDIT_W-1:0];
                  state_d  = COLLECT;
               end
            end else if (restock && (state_q == IDLE)) begin
               reload_c = 1'b1;
            end
         end
         VEND: begin
            coin_reject_d = coin_valid;
            out_d         = 1'b1;
            out_item_d    = vend_item_q;
            state_d       = (credit_q != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            coin_reject_d  = coin_valid;
            change_valid_d = 1'b1;
            change_d       = credit_q;
            credit_d       = '0;
            state_d        = IDLE;
         end
         default: begin
            state_d  = IDLE;
            credit_d = '0;
         end
      endcase

      busy_d = (state_d == VEND) || (state_d == CHANGE);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q        <= IDLE;
         credit_q       <= '0;
         vend_item_q    <= '0;
         out_q          <= 1'b0;
         out_item_q     <= '0;
         change_q       <= '0;
         change_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         coin_reject_q  <= 1'b0;
         sold_out_q     <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         vend_item_q    <= vend_item_d;
         out_q          <= out_d;
         out_item_q     <= out_item_d;
         change_q       <= change_d;
         change_valid_q <= change_valid_d;
         busy_q         <= busy_d;
         coin_reject_q  <= coin_reject_d;
         sold_out_q     <= sold_out_d;
         err_q          <= err_d;
      end
   end

   assign out          = out_q;
   assign out_item     = out_item_q;
   assign change       = change_q;
   assign change_valid = change_valid_q;
   assign credit       = credit_q;
   assign busy         = busy_q;
   assign coin_reject  = coin_reject_q;
   assign sold_out     = sold_out_q;
   assign err          = err_q;

`ifdef VM_SALES_AUDIT_EN
   localparam int unsigned AUDIT_W   = 16;
   localparam int unsigned AUDIT_S_W = AUDIT_W + 1;

   logic [AUDIT_W-1:0]   revenue_q, revenue_d;
   logic [AUDIT_W-1:0]   vend_count_q, vend_count_d;
   logic [AUDIT_S_W-1:0] rev_sum_c;

   // Sales totals, saturating; advanced on the cycle the item dispenses.
   always_comb begin
      revenue_d    = revenue_q;
      vend_count_d = vend_count_q;
      rev_sum_c    = {1'b0, revenue_q} + AUDIT_S_W'(item_price(32'(vend_item_q)));
      if (state_q == VEND) begin
         revenue_d = rev_sum_c[AUDIT_W] ? '1 : rev_sum_c[AUDIT_W-1:0];
         if (vend_count_q != '1) begin
            vend_count_d = vend_count_q + AUDIT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         revenue_q    <= '0;
         vend_count_q <= '0;
      end else begin
         revenue_q    <= revenue_d;
         vend_count_q <= vend_count_d;
      end
   end

   assign revenue    = revenue_q;
   assign vend_count = vend_count_q;
`endif

endmodule
